// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width and the opcodes the alu64 datapath understands.
package alu_pkg;

  localparam int unsigned ALU_W    = 64;
  localparam int unsigned ALU_OP_W = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD = 4'h0,
    ALU_SUB = 4'h1
  } alu_op_e;

endpackage

// File: rtl/alu_rsp_fifo.sv
// In-order response buffer: registered storage, head entry drives the output, no fall-through.
module alu_rsp_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 68
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_wr_en;
  logic             w_rd_en;

  assign w_wr_en = i_push && !o_full;
  assign w_rd_en = i_pop && !o_empty;

  // Extra wrap bit distinguishes full from empty when the index bits match.
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_dout  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                        r_mem[g] <= '0;
      else if (w_wr_en && (r_wr_ptr[AW-1:0] == AW'(g)))  r_mem[g] <= i_din;
    end
  end

endmodule

// File: rtl/alu64_issue_ctrl.sv
// Issue-side controller for alu64: credit-gated command issue, fixed-latency result capture,
// and in-order buffered responses.
module alu64_issue_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned ALU_LAT   = 1,
  parameter int unsigned RSP_DEPTH = 4,
  parameter int unsigned TAG_W     = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ALU_OP_W-1:0] cmd_opcode,
  input  logic [ALU_W-1:0]    cmd_a,
  input  logic [ALU_W-1:0]    cmd_b,
  input  logic [TAG_W-1:0]    cmd_tag,
  output logic                alu_valid,
  output logic [ALU_OP_W-1:0] alu_opcode,
  output logic [ALU_W-1:0]    alu_op_a,
  output logic [ALU_W-1:0]    alu_op_b,
  input  logic [ALU_W-1:0]    alu_result,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [ALU_W-1:0]    rsp_result,
  output logic [TAG_W-1:0]    rsp_tag
);

  localparam int unsigned CW = $clog2(RSP_DEPTH + 1);

  // Tag width is a module parameter, so the response payload is typed here.
  typedef struct packed {
    logic [ALU_W-1:0] result;
    logic [TAG_W-1:0] tag;
  } alu_rsp_t;

  localparam int unsigned RSP_W = $bits(alu_rsp_t);

  logic [CW-1:0]       r_credits;
  logic [ALU_OP_W-1:0] r_opcode;
  logic [ALU_W-1:0]    r_op_a;
  logic [ALU_W-1:0]    r_op_b;
  logic                r_stg_vld [ALU_LAT+1];
  logic [TAG_W-1:0]    r_stg_tag [ALU_LAT+1];

  logic                w_accept;
  logic                w_pop;
  logic                w_push;
  logic                w_full;
  logic                w_empty;
  alu_rsp_t            w_push_data;
  alu_rsp_t            w_head;

  assign cmd_ready = rst_n && (r_credits != '0);
  assign w_accept  = cmd_valid && cmd_ready;
  assign w_pop     = rsp_valid && rsp_ready;

  // One credit per op, held from accept until its response leaves the buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    r_credits <= CW'(RSP_DEPTH);
    else if (w_accept && !w_pop)   r_credits <= r_credits - CW'(1);
    else if (!w_accept && w_pop)   r_credits <= r_credits + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opcode <= '0;
      r_op_a   <= '0;
      r_op_b   <= '0;
    end else if (w_accept) begin
      r_opcode <= cmd_opcode;
      r_op_a   <= cmd_a;
      r_op_b   <= cmd_b;
    end
  end

  // Stage 0 is the ALU request cycle itself; the last stage lines up with a valid result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stg_vld[0] <= 1'b0;
      r_stg_tag[0] <= '0;
    end else begin
      r_stg_vld[0] <= w_accept;
      if (w_accept) r_stg_tag[0] <= cmd_tag;
    end
  end

  for (genvar g = 1; g <= ALU_LAT; g++) begin : g_stage
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_stg_vld[g] <= 1'b0;
        r_stg_tag[g] <= '0;
      end else begin
        r_stg_vld[g] <= r_stg_vld[g-1];
        r_stg_tag[g] <= r_stg_tag[g-1];
      end
    end
  end

  assign alu_valid  = r_stg_vld[0];
  assign alu_opcode = r_opcode;
  assign alu_op_a   = r_op_a;
  assign alu_op_b   = r_op_b;

  assign w_push      = r_stg_vld[ALU_LAT] && !w_full;
  assign w_push_data = '{result: alu_result, tag: r_stg_tag[ALU_LAT]};

  alu_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (RSP_W)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_din   (w_push_data),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign rsp_valid  = !w_empty;
  assign rsp_result = w_head.result;
  assign rsp_tag    = w_head.tag;

  // Credits reserve a slot for every in-flight op, so a result never meets a full buffer.
  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
                                   !(r_stg_vld[ALU_LAT] && w_full))
    else $error("result arrived while response buffer full");

endmodule
